// File: rtl/branch_pkg.sv
// Shared definitions for the RV32I branch-compare pipeline: funct3 codes,
// the stage-1 payload layout and the stage-2 combine function.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Partial compare results captured in stage 1 and combined in stage 2.
  typedef struct packed {
    logic       msb_a;
    logic       msb_b;
    logic       eq_hi;
    logic       lt_hi;
    logic       eq_lo;
    logic       lt_lo;
    logic [2:0] funct3;
  } s1_payload_t;

  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic branch_taken(input s1_payload_t p);
    logic mag_eq;
    logic mag_lt;
    logic eq;
    logic slt;
    logic ult;
    logic t;
    mag_eq = p.eq_hi && p.eq_lo;
    mag_lt = p.lt_hi || (p.eq_hi && p.lt_lo);
    eq     = (p.msb_a == p.msb_b) && mag_eq;
    // With differing sign bits the MSB alone decides both orderings.
    slt    = (p.msb_a != p.msb_b) ? p.msb_a : mag_lt;
    ult    = (p.msb_a != p.msb_b) ? p.msb_b : mag_lt;
    case (p.funct3)
      F3_BEQ:  t = eq;
      F3_BNE:  t = !eq;
      F3_BLT:  t = slt;
      F3_BGE:  t = !slt;
      F3_BLTU: t = ult;
      F3_BGEU: t = !ult;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mag_split_compare.sv
// Combinational W-bit unsigned compare producing equal and less-than flags.
module mag_split_compare #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq,
  output logic         o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a < i_b);

endmodule

// File: rtl/branch_compare_pipe.sv
// Two-stage branch-condition evaluator: stage 1 splits and partially compares
// the operands, stage 2 combines per funct3 into a registered decision.
module branch_compare_pipe
  import branch_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int SPLIT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      rs1,
  input  logic [31:0]      rs2,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             w_eq_hi;
  logic             w_lt_hi;
  logic             w_eq_lo;
  logic             w_lt_lo;
  logic             w_adv1;
  logic             w_adv2;
  s1_payload_t      w_s1_next;

  logic             r_s1_valid;
  s1_payload_t      r_s1;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_out_valid;
  logic             r_taken;
  logic             r_illegal;
  logic [TAG_W-1:0] r_out_tag;

  mag_split_compare #(.W(31 - SPLIT)) u_cmp_hi (
    .i_a  (rs1[30:SPLIT]),
    .i_b  (rs2[30:SPLIT]),
    .o_eq (w_eq_hi),
    .o_lt (w_lt_hi)
  );

  mag_split_compare #(.W(SPLIT)) u_cmp_lo (
    .i_a  (rs1[SPLIT-1:0]),
    .i_b  (rs2[SPLIT-1:0]),
    .o_eq (w_eq_lo),
    .o_lt (w_lt_lo)
  );

  // in_ready depends only on out_ready and the valid bits, never on in_valid.
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  always_comb begin
    w_s1_next        = '0;
    w_s1_next.msb_a  = rs1[31];
    w_s1_next.msb_b  = rs2[31];
    w_s1_next.eq_hi  = w_eq_hi;
    w_s1_next.lt_hi  = w_lt_hi;
    w_s1_next.eq_lo  = w_eq_lo;
    w_s1_next.lt_lo  = w_lt_lo;
    w_s1_next.funct3 = funct3;
  end

  always_ff @(posedge i_clk) begin
    if (w_adv1 && in_valid) begin
      r_s1     <= w_s1_next;
      r_s1_tag <= tag;
    end
  end

  // Flush wins over any advance; a stalled result is discarded with the rest.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_taken     <= 1'b0;
      r_illegal   <= 1'b0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_taken   <= branch_taken(r_s1);
          r_illegal <= is_illegal_f3(r_s1.funct3);
          r_out_tag <= r_s1_tag;
        end
      end
      if (w_adv1) begin
        r_s1_valid <= in_valid;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign taken     = r_taken;
  assign illegal   = r_illegal;
  assign out_tag   = r_out_tag;

endmodule
